// File: rtl/uart_pkg.sv
// Shared UART constants used by the RX, TX, controller and TX FIFO blocks.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam logic [UART_DATA_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [UART_DATA_W-1:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-side bundle of the UART TX FIFO; master = producer/TX side, slave = FIFO.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
);

  logic [UART_DATA_W-1:0] wr_data_i;
  logic                   wr_en_i;
  logic [UART_DATA_W-1:0] tx_data_o;
  logic                   tx_data_valid_o;
  logic                   tx_data_ready_i;
  logic [PTR_W:0]         count_o;
  logic                   full_o;
  logic                   empty_o;
  logic                   overflow_o;

  modport master (
    output wr_data_i, wr_en_i, tx_data_ready_i,
    input  tx_data_o, tx_data_valid_o, count_o, full_o, empty_o, overflow_o
  );

  modport slave (
    input  wr_data_i, wr_en_i, tx_data_ready_i,
    output tx_data_o, tx_data_valid_o, count_o, full_o, empty_o, overflow_o
  );

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// Distributed-RAM byte store: synchronous write, asynchronous read.
// With UART_TX_FIFO_CRLF_EN a second write port stores the LF of a CR/LF pair.
module uart_tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en_a,
  input  logic [PTR_W-1:0]       wr_addr_a,
  input  logic [UART_DATA_W-1:0] wr_data_a,
`ifdef UART_TX_FIFO_CRLF_EN
  input  logic                   wr_en_b,
  input  logic [PTR_W-1:0]       wr_addr_b,
  input  logic [UART_DATA_W-1:0] wr_data_b,
`endif
  input  logic [PTR_W-1:0]       rd_addr,
  output logic [UART_DATA_W-1:0] rd_data
);

  logic [UART_DATA_W-1:0] mem_r [DEPTH];

  // Storage write ports; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_a) begin
      mem_r[wr_addr_a] <= wr_data_a;
    end
`ifdef UART_TX_FIFO_CRLF_EN
    if (wr_en_b) begin
      mem_r[wr_addr_b] <= wr_data_b;
    end
`endif
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter; drops and flags writes when full.
// Optional macro UART_TX_FIFO_CRLF_EN expands each LF write into a CR/LF pair.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic           clk_i,
  input logic           rst_i,
  uart_tx_fifo_if.slave bus
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             full_r;
  logic             empty_r;
  logic             overflow_r;

  logic             pop_s;
  logic             wr_one_s;
  logic             drop_s;
  logic [PTR_W:0]   wr_cnt_s;
  logic [PTR_W:0]   count_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
`ifdef UART_TX_FIFO_CRLF_EN
  localparam logic [PTR_W:0] PAIR_MAX = (PTR_W+1)'(DEPTH - 2);
  logic             wr_two_s;
`endif

  assign pop_s = ~empty_r & bus.tx_data_ready_i;

  // Write acceptance and next count/pointer; a same-cycle pop never frees space for a write.
  always_comb begin
    wr_one_s = 1'b0;
    drop_s   = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    wr_two_s = 1'b0;
    if (bus.wr_en_i && (bus.wr_data_i == ASCII_LF)) begin
      if (count_r <= PAIR_MAX) begin
        wr_two_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else if (bus.wr_en_i) begin
      if (!full_r) begin
        wr_one_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      drop_s = 1'b0;
    end
    wr_cnt_s = (PTR_W+1)'({wr_two_s, wr_one_s});
`else
    if (bus.wr_en_i) begin
      if (!full_r) begin
        wr_one_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      drop_s = 1'b0;
    end
    wr_cnt_s = (PTR_W+1)'(wr_one_s);
`endif
    count_nxt_s  = count_r + wr_cnt_s - (PTR_W+1)'(pop_s);
    wr_ptr_nxt_s = wr_ptr_r + wr_cnt_s[PTR_W-1:0];
  end

  // Pointer, count and registered status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {(PTR_W+1){1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_r + PTR_W'(pop_s);
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == DEPTH_CNT);
      empty_r    <= (count_nxt_s == {(PTR_W+1){1'b0}});
      overflow_r <= overflow_r | drop_s;
    end
  end

  uart_tx_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk       (clk_i),
`ifdef UART_TX_FIFO_CRLF_EN
    .wr_en_a   (wr_one_s | wr_two_s),
    .wr_addr_a (wr_ptr_r),
    .wr_data_a (wr_two_s ? ASCII_CR : bus.wr_data_i),
    .wr_en_b   (wr_two_s),
    .wr_addr_b (wr_ptr_r + PTR_W'(1)),
    .wr_data_b (ASCII_LF),
`else
    .wr_en_a   (wr_one_s),
    .wr_addr_a (wr_ptr_r),
    .wr_data_a (bus.wr_data_i),
`endif
    .rd_addr   (rd_ptr_r),
    .rd_data   (bus.tx_data_o)
  );

  assign bus.tx_data_valid_o = ~empty_r;
  assign bus.count_o         = count_r;
  assign bus.full_o          = full_r;
  assign bus.empty_o         = empty_r;
  assign bus.overflow_o      = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model, vector table, directed corners, random traffic.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic clk;
  logic rst;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  logic       m_ovf;
  logic [7:0] popped[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: FIFO as a queue; acceptance decided on the occupancy before the edge.
  task automatic model_step(input logic r, input logic we, input logic [7:0] d, input logic rdy);
    int sz;
    sz = mq.size();
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (sz > 0 && rdy) void'(mq.pop_front());
      if (we) begin
`ifdef UART_TX_FIFO_CRLF_EN
        if (d == 8'h0A) begin
          if (sz <= DEPTH - 2) begin
            mq.push_back(8'h0D);
            mq.push_back(8'h0A);
          end else begin
            m_ovf = 1'b1;
          end
        end else
`endif
        if (sz < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic we, input logic [7:0] d, input logic rdy);
    rst = r;
    bus.wr_en_i = we;
    bus.wr_data_i = d;
    bus.tx_data_ready_i = rdy;
    if (!r && bus.tx_data_valid_o === 1'b1 && rdy) popped.push_back(bus.tx_data_o);
    @(posedge clk);
    model_step(r, we, d, rdy);
    #1;
    chk("count", 32'(bus.count_o), 32'(mq.size()));
    chk("empty", 32'(bus.empty_o), 32'(mq.size() == 0));
    chk("full", 32'(bus.full_o), 32'(mq.size() == DEPTH));
    chk("valid", 32'(bus.tx_data_valid_o), 32'(mq.size() != 0));
    chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
    if (mq.size() != 0) chk("head", 32'(bus.tx_data_o), 32'(mq[0]));
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * DEPTH && mq.size() != 0; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_empty", 32'(bus.empty_o), 32'd1);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    popped.delete();
  endtask

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       rdy;
    int         exp_count;
    logic       exp_valid;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vt[8];

  initial begin
    rst = 1'b1;
    bus.wr_en_i = 1'b0;
    bus.wr_data_i = 8'h00;
    bus.tx_data_ready_i = 1'b0;
    m_ovf = 1'b0;
    repeat (2) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reset_count", 32'(bus.count_o), 32'd0);
    chk("reset_empty", 32'(bus.empty_o), 32'd1);

    // Reset mid-stream with count 5, colliding with a write and a ready
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    chk("pre_rst_count", 32'(bus.count_o), 32'd5);
    cycle(1'b1, 1'b1, 8'h33, 1'b1);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_valid", 32'(bus.tx_data_valid_o), 32'd0);
    cycle(1'b0, 1'b1, 8'h41, 1'b0);
    chk("first_head", 32'(bus.tx_data_o), 32'h41);
    chk("first_valid", 32'(bus.tx_data_valid_o), 32'd1);

    // Vector table: simultaneous write/pop at count 3 then drain
    vt[0] = '{1'b1, 8'h41, 1'b0, 1, 1'b1, 8'h41};
    vt[1] = '{1'b1, 8'h42, 1'b0, 2, 1'b1, 8'h41};
    vt[2] = '{1'b1, 8'h43, 1'b0, 3, 1'b1, 8'h41};
    vt[3] = '{1'b1, 8'h55, 1'b1, 3, 1'b1, 8'h42};
    vt[4] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h43};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h55};
    vt[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
`ifdef UART_TX_FIFO_CRLF_EN
    vt[7] = '{1'b1, 8'h0A, 1'b0, 2, 1'b1, 8'h0D};
`else
    vt[7] = '{1'b1, 8'h0A, 1'b0, 1, 1'b1, 8'h0A};
`endif
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, vt[i].we, vt[i].d, vt[i].rdy);
      chk("vec_count", 32'(bus.count_o), 32'(vt[i].exp_count));
      chk("vec_valid", 32'(bus.tx_data_valid_o), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) chk("vec_head", 32'(bus.tx_data_o), 32'(vt[i].exp_head));
    end
    drain();

    // Ordering, overflow on full, and full+pop+write
    do_reset();
    for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    chk("full_flag", 32'(bus.full_o), 32'd1);
    chk("full_count", 32'(bus.count_o), 32'd16);
    cycle(1'b0, 1'b1, 8'h99, 1'b0);
    chk("ovf_set", 32'(bus.overflow_o), 32'd1);
    chk("ovf_count", 32'(bus.count_o), 32'd16);
    cycle(1'b0, 1'b1, 8'h77, 1'b1);
    chk("fullpop_count", 32'(bus.count_o), 32'd15);
    drain();
    chk("order_len", 32'(popped.size()), 32'd16);
    for (int i = 0; i < popped.size() && i < 16; i++) chk("order_byte", 32'(popped[i]), 32'(i + 1));

    // Pointer wrap under a toggling ready
    do_reset();
    begin
      int nxt;
      nxt = 0;
      for (int c = 0; c < 200 && (nxt < 40 || mq.size() != 0); c++) begin
        logic w;
        w = (nxt < 40) && (mq.size() < DEPTH);
        cycle(1'b0, w, 8'(nxt), 1'(((c / 3) % 2)));
        if (w) nxt++;
      end
    end
    chk("wrap_ovf", 32'(bus.overflow_o), 32'd0);
    chk("wrap_len", 32'(popped.size()), 32'd40);
    for (int i = 0; i < popped.size() && i < 40; i++) chk("wrap_byte", 32'(popped[i]), 32'(i));

`ifdef UART_TX_FIFO_CRLF_EN
    do_reset();
    cycle(1'b0, 1'b1, 8'h48, 1'b0);
    cycle(1'b0, 1'b1, 8'h0A, 1'b0);
    chk("crlf_peak", 32'(bus.count_o), 32'd3);
    drain();
    chk("crlf_len", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("crlf_b0", 32'(popped[0]), 32'h48);
      chk("crlf_b1", 32'(popped[1]), 32'h0D);
      chk("crlf_b2", 32'(popped[2]), 32'h0A);
    end
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'h0A, 1'b0);
    chk("crlf_drop_count", 32'(bus.count_o), 32'd15);
    chk("crlf_drop_ovf", 32'(bus.overflow_o), 32'd1);
    drain();
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
      cycle(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 2) != 0), d, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO between byte producers (DM-slave printf path, RX echo) and the UART transmitter. Producers push single bytes with a write strobe and never stall. The block holds them in order and presents them to the transmitter over its valid/ready handshake. This decouples bursts of `send_data` characters from the 115200-baud line rate.

## Interface
Parameters:
- `DEPTH`, default 16: number of byte entries. Must be a power of two, minimum 4.
- `PTR_W`, default `$clog2(DEPTH)`: pointer width. Derived; never overridden.

Ports:
- `clk_i` in 1: system clock (27 MHz `sys_clk`). Single clock domain.
- `rst_i` in 1: synchronous reset, active-high.
- `wr_data_i` in 8: byte to enqueue.
- `wr_en_i` in 1: enqueue strobe, one byte per cycle.
- `tx_data_o` out 8: head byte, wired to the transmitter's `tx_data`.
- `tx_data_valid_o` out 1: head byte is valid, wired to `tx_data_valid`.
- `tx_data_ready_i` in 1: transmitter is idle and accepts a byte, from `tx_data_ready`.
- `count_o` out `PTR_W+1`: number of entries currently stored.
- `full_o` out 1: `count_o == DEPTH`.
- `empty_o` out 1: `count_o == 0`.
- `overflow_o` out 1: sticky flag, set when a write is dropped.

## Operation
- Storage is a circular array `mem[DEPTH]` with write pointer `wr_ptr`, read pointer `rd_ptr`, and a separate `count` register. Pointers wrap modulo `DEPTH` by natural `PTR_W` overflow.
- **Reset:** `wr_ptr`=0, `rd_ptr`=0, `count`=0, `overflow_o`=0. After reset: `tx_data_valid_o`=0, `empty_o`=1, `full_o`=0, `count_o`=0. `mem` contents are not reset, and `tx_data_o` is don't-care while empty. Reset has priority over every other event, including a write or pop in the same cycle.
- **Enqueue:** when `wr_en_i` is high and `full_o` is low, do `mem[wr_ptr] <= wr_data_i` and `wr_ptr++`.
- **Write while full:** if `full_o` is high, the write is dropped, state is unchanged, and `overflow_o` is set. This holds even if a pop happens in the same cycle; a same-cycle pop does not make room for a full-FIFO write.
- **Dequeue (pop):** a pop occurs on any cycle with `tx_data_valid_o && tx_data_ready_i`; then `rd_ptr++`.
- **Head presentation:** first-word-fall-through. `tx_data_o = mem[rd_ptr]` and `tx_data_valid_o = !empty_o`.
- **Count update:** `count` increases by 1 on write only, decreases by 1 on pop only, and is unchanged when both happen in the same cycle.
- **Overflow flag:** cleared only by `rst_i`.
- There is no separate state machine. State is fully defined by (`count`, pointers). Empty and non-empty behaviour follow from the flags above.

## Timing
- **Write-to-valid latency:** 1 cycle. A write in cycle N gives `tx_data_valid_o`=1 and the byte on `tx_data_o` in cycle N+1. There is no same-cycle bypass when empty.
- **Pop-to-next-head:** the next byte appears in the cycle after the pop.
- **Sustained rate:** back-to-back pops are allowed (1 byte/cycle) if `tx_data_ready_i` stays high. In practice the transmitter drops ready for ~234 cycles per bit × 10 bits.
- **Registered status:** `full_o`, `empty_o` and `count_o` are registered and reflect the state after the previous edge.
- **Valid stability:** `tx_data_valid_o` never drops while `tx_data_ready_i` is low and the FIFO is non-empty. `tx_data_o` is stable until popped.

## Configuration
- Macro `UART_TX_FIFO_CRLF_EN`.
- **Defined:** a write of 0x0A enqueues two entries, 0x0D then 0x0A, in one cycle (`wr_ptr += 2`, `count += 2`, minus 1 for a same-cycle pop).
  - The write is accepted only if `count <= DEPTH-2`. Otherwise both bytes are dropped and `overflow_o` is set; LF is never split from its CR.
  - All other bytes behave as normal.
- **Undefined:** 0x0A is an ordinary byte, and the logic is absent.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_W` = 8
  - `ASCII_CR` = 8'h0D
  - `ASCII_LF` = 8'h0A

  `uart_rx`, `uart_tx` and `uart_controller` use the same package.
- Sub-module `uart_tx_fifo_mem` holds the storage:
  - Distributed-RAM array with a synchronous write port, two write ports when CRLF is enabled, and an asynchronous read port.
  - Keeps pointer/count logic separate from the memory inference on the Gowin target.

## Test plan
- **Reset and first byte:** pulse `rst_i` mid-stream with `count_o`=5 → next cycle `count_o`=0, `empty_o`=1, `tx_data_valid_o`=0. Then write 0x41 → `tx_data_o`=0x41 and valid=1 one cycle later.
- **Ordering:** write 0x01..0x10 with `tx_data_ready_i`=0 → `full_o`=1 and `count_o`=16. A 17th write of 0x99 → `overflow_o`=1, `count_o` stays 16. Release ready → bytes pop as 0x01..0x10, 0x99 is never seen, and `empty_o`=1 after 16 pops.
- **Simultaneous write/pop:** with `count_o`=3 and ready=1, write 0x55 in the same cycle as a pop → `count_o` stays 3 and 0x55 is emitted last.
- **Full + pop + write:** with `count_o`=16, write 0x77 in the same cycle as a pop → `count_o`=15, `overflow_o`=1, and 0x77 is absent from the output.
- **Pointer wrap:** stream 40 bytes 0x00..0x27 with ready toggling every 3 cycles, never exceeding 16 stored → output sequence is identical and `overflow_o`=0.
- **CRLF (`UART_TX_FIFO_CRLF_EN`):** write 0x48, 0x0A → output 0x48, 0x0D, 0x0A and `count_o` peaks at 3. With `count_o`=15, write 0x0A → dropped, `overflow_o`=1, `count_o` stays 15.
